// File: rtl/pcm_interp.sv
// PCM linear interpolator: buffers audio-rate samples in a small FIFO and emits
// one linearly interpolated sample per clk between consecutive input samples.
module pcm_interp #(
    parameter int WIDTH    = 16,
    parameter int OSR_LOG2 = 6,
    parameter int FIFO_AW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_pcm,
    output logic [WIDTH-1:0]   pcm,
    output logic               underrun,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = WIDTH + 1 + OSR_LOG2;
    localparam logic [FIFO_AW:0]    FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
    localparam logic [OSR_LOG2-1:0] LAST_PHASE = {OSR_LOG2{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [WIDTH-1:0]          mem_r [DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr_r;
    logic [FIFO_AW-1:0]        rd_ptr_r;
    logic [FIFO_AW:0]          level_r;

    state_t                    state_r;
    logic [OSR_LOG2-1:0]       phase_r;
    logic signed [WIDTH-1:0]   prev_r;
    logic signed [WIDTH-1:0]   next_r;
    logic signed [WIDTH-1:0]   pcm_r;
    logic                      underrun_r;

    logic                      full_s;
    logic                      empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      boundary_s;
    logic signed [WIDTH-1:0]   pop_data_s;
    logic signed [WIDTH:0]     diff_s;
    logic signed [PW-1:0]      diff_ext_s;
    logic signed [PW-1:0]      phase_ext_s;
    logic signed [PW-1:0]      prod_s;
    logic signed [PW-1:0]      step_s;
    logic signed [PW-1:0]      interp_s;
    logic                      unused_s;

    assign full_s     = (level_r == FULL_LEVEL);
    assign empty_s    = (level_r == {(FIFO_AW+1){1'b0}});
    assign push_s     = in_valid & ~full_s;
    assign boundary_s = (phase_r == LAST_PHASE);
    assign pop_data_s = mem_r[rd_ptr_r];

    // Widened datapath: a full-scale step still fits in diff and in the product.
    assign diff_s      = {next_r[WIDTH-1], next_r} - {prev_r[WIDTH-1], prev_r};
    assign diff_ext_s  = {{OSR_LOG2{diff_s[WIDTH]}}, diff_s};
    assign phase_ext_s = {{(WIDTH+1){1'b0}}, phase_r};
    assign prod_s      = diff_ext_s * phase_ext_s;
    assign step_s      = prod_s >>> OSR_LOG2;
    assign interp_s    = {{(PW-WIDTH){prev_r[WIDTH-1]}}, prev_r} + step_s;
    assign unused_s    = ^interp_s[PW-1:WIDTH];

    assign in_ready   = ~full_s;
    assign pcm        = pcm_r;
    assign underrun   = underrun_r;
    assign fifo_level = level_r;

    // Pop request: first sample out of IDLE, then once per segment boundary.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = ~empty_s;
            ST_RUN:  pop_s = boundary_s & ~empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_pcm;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (FIFO_AW+1)'(1);
                2'b01:   level_r <= level_r - (FIFO_AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Segment sequencer and registered interpolated output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= {OSR_LOG2{1'b0}};
            prev_r     <= {WIDTH{1'b0}};
            next_r     <= {WIDTH{1'b0}};
            pcm_r      <= {WIDTH{1'b0}};
            underrun_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pcm_r      <= {WIDTH{1'b0}};
                    underrun_r <= 1'b0;
                    if (!empty_s) begin
                        next_r  <= pop_data_s;
                        prev_r  <= {WIDTH{1'b0}};
                        phase_r <= {OSR_LOG2{1'b0}};
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    phase_r <= phase_r + OSR_LOG2'(1);
                    pcm_r   <= interp_s[WIDTH-1:0];
                    if (boundary_s) begin
                        // An empty FIFO leaves next alone, so the output goes flat.
                        prev_r     <= next_r;
                        underrun_r <= empty_s;
                        if (!empty_s) begin
                            next_r <= pop_data_s;
                        end
                    end else begin
                        underrun_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    phase_r    <= {OSR_LOG2{1'b0}};
                    prev_r     <= {WIDTH{1'b0}};
                    next_r     <= {WIDTH{1'b0}};
                    pcm_r      <= {WIDTH{1'b0}};
                    underrun_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
